// File: rtl/ex_mem_stage_pkg.sv
// Shared types for the execute->memory stage: exception opcodes, stage payload
// and skid-buffer state encodings.
package ex_mem_stage_pkg;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int EXC_REG = 30;

    typedef enum logic [1:0] {
        EXC_NONE = 2'd0,
        EXC_ADD  = 2'd1,
        EXC_ADDI = 2'd2,
        EXC_SUB  = 2'd3
    } exc_op_e;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [REG_W-1:0]  rd;
        logic              wen;
        logic [DATA_W-1:0] store_data;
        logic              mem_we;
        logic [DATA_W-1:0] pc;
        logic              exception;
    } stage_payload_t;

endpackage

// File: rtl/ex_mem_stage_exc_rewrite.sv
// Combinational overflow-exception rewrite of a stage payload; shared with the
// multdiv path so both report overflow status the same way.
module exc_rewrite
    import ex_mem_stage_pkg::*;
(
    input  stage_payload_t in_pay,
    input  logic           overflow,
    input  logic [1:0]     exc_op,
    output stage_payload_t out_pay
);

    always_comb begin
        out_pay = in_pay;
        // Status code is the opcode itself, so software can tell add/addi/sub apart.
        if (overflow && (exc_op != EXC_NONE)) begin
            out_pay.result    = DATA_W'(exc_op);
            out_pay.rd        = REG_W'(EXC_REG);
            out_pay.wen       = 1'b1;
            out_pay.mem_we    = 1'b0;
            out_pay.exception = 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute->memory pipeline stage: overflow rewrite plus a 2-entry skid buffer.
// Optional exception-delivery counter enabled by EXC_COUNT_EN.
//
// state     | meaning
// BUF_EMPTY | no valid entries, in_ready = 1
// BUF_ONE   | main entry valid, in_ready = 1
// BUF_TWO   | main and skid valid, in_ready = 0
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_overflow,
    input  logic [1:0]        in_exc_op,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_wen,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic              in_mem_we,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_wen,
    output logic [DATA_W-1:0] out_store_data,
    output logic              out_mem_we,
    output logic [DATA_W-1:0] out_pc,
    output logic              out_exception
`ifdef EXC_COUNT_EN
    ,
    output logic [31:0]       exc_count
`endif
);

    buf_state_e     state_q, state_d;
    stage_payload_t main_q, main_d;
    stage_payload_t skid_q, skid_d;
    stage_payload_t raw_pay, cap_pay;
    logic           accept, deliver;

    assign raw_pay = '{result:     in_result,
                       rd:         in_rd,
                       wen:        in_wen,
                       store_data: in_store_data,
                       mem_we:     in_mem_we,
                       pc:         in_pc,
                       exception:  1'b0};

    exc_rewrite u_exc_rewrite (
        .in_pay   (raw_pay),
        .overflow (in_overflow),
        .exc_op   (in_exc_op),
        .out_pay  (cap_pay)
    );

    assign in_ready  = (state_q != BUF_TWO);
    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        state_d = BUF_ONE;
                        main_d  = cap_pay;
                    end
                end
                BUF_ONE: begin
                    if (accept && deliver) begin
                        main_d = cap_pay;
                    end else if (accept) begin
                        state_d = BUF_TWO;
                        skid_d  = cap_pay;
                    end else if (deliver) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (deliver) begin
                        state_d = BUF_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_result     = main_q.result;
    assign out_rd         = main_q.rd;
    assign out_wen        = main_q.wen & out_valid;
    assign out_store_data = main_q.store_data;
    assign out_mem_we     = main_q.mem_we & out_valid;
    assign out_pc         = main_q.pc;
    assign out_exception  = main_q.exception;

`ifdef EXC_COUNT_EN
    logic [31:0] exc_count_q, exc_count_d;

    always_comb begin
        exc_count_d = exc_count_q;
        if (deliver && main_q.exception) begin
            exc_count_d = exc_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exc_count_q <= '0;
        end else begin
            exc_count_q <= exc_count_d;
        end
    end

    assign exc_count = exc_count_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage; expected payloads are queued on accept
// and compared on deliver.
module tb_ex_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_result = '0;
    logic        in_overflow = 1'b0;
    logic [1:0]  in_exc_op = '0;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic [31:0] in_store_data = '0;
    logic        in_mem_we = 1'b0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_store_data;
    logic        out_mem_we;
    logic [31:0] out_pc;
    logic        out_exception;
`ifdef EXC_COUNT_EN
    logic [31:0] exc_count;
`endif

    ex_mem_stage dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_result      (in_result),
        .in_overflow    (in_overflow),
        .in_exc_op      (in_exc_op),
        .in_rd          (in_rd),
        .in_wen         (in_wen),
        .in_store_data  (in_store_data),
        .in_mem_we      (in_mem_we),
        .in_pc          (in_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_rd         (out_rd),
        .out_wen        (out_wen),
        .out_store_data (out_store_data),
        .out_mem_we     (out_mem_we),
        .out_pc         (out_pc),
        .out_exception  (out_exception)
`ifdef EXC_COUNT_EN
        ,
        .exc_count      (exc_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wen;
        logic        mem_we;
        logic        exc;
        logic [31:0] store;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = '0;
    logic        stab_pend = 1'b0;
    logic [31:0] stab_result, stab_pc;
    logic [4:0]  stab_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model();
        exp_t e;
        e.result = in_result;
        e.rd     = in_rd;
        e.wen    = in_wen;
        e.mem_we = in_mem_we;
        e.exc    = 1'b0;
        e.store  = in_store_data;
        e.pc     = in_pc;
        if (in_overflow && in_exc_op != 2'd0) begin
            e.result = {30'd0, in_exc_op};
            e.rd     = 5'd30;
            e.wen    = 1'b1;
            e.mem_we = 1'b0;
            e.exc    = 1'b1;
        end
        return e;
    endfunction

    // Inputs are set at a falling edge; this samples mid-low-phase, then waits
    // for the next falling edge (one rising edge in between).
    task automatic tick();
        exp_t e;
        #1;
        if (!out_valid) begin
            chk("wen_gated", {31'd0, out_wen}, 32'd0);
            chk("mem_we_gated", {31'd0, out_mem_we}, 32'd0);
        end
        if (stab_pend && out_valid) begin
            chk("stable_result", out_result, stab_result);
            chk("stable_rd", {27'd0, out_rd}, {27'd0, stab_rd});
            chk("stable_pc", out_pc, stab_pc);
        end
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("result", out_result, e.result);
                    chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("wen", {31'd0, out_wen}, {31'd0, e.wen});
                    chk("mem_we", {31'd0, out_mem_we}, {31'd0, e.mem_we});
                    chk("exception", {31'd0, out_exception}, {31'd0, e.exc});
                    chk("store_data", out_store_data, e.store);
                    chk("pc", out_pc, e.pc);
                    if (e.exc) exp_cnt = exp_cnt + 32'd1;
                end
            end
            if (in_valid && in_ready) sb_q.push_back(model());
        end
        stab_pend   = out_valid && !out_ready && !flush;
        stab_result = out_result;
        stab_rd     = out_rd;
        stab_pc     = out_pc;
        @(negedge clock);
    endtask

    task automatic send(input logic [31:0] res, input logic ovf, input logic [1:0] op,
                        input logic [4:0] rd, input logic mwe);
        in_valid      = 1'b1;
        in_result     = res;
        in_overflow   = ovf;
        in_exc_op     = op;
        in_rd         = rd;
        in_wen        = ~mwe;
        in_mem_we     = mwe;
        in_store_data = res ^ 32'hA5A5_0000;
        in_pc         = in_pc + 32'd4;
        tick();
    endtask

    task automatic drain(input int max_cycles);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < max_cycles && (sb_q.size() != 0 || out_valid); i++) tick();
        chk("drain_empty", sb_q.size(), 32'd0);
        chk("drain_idle", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        send(32'h11, 1'b0, 2'd0, 5'd1, 1'b0);
        send(32'h22, 1'b1, 2'd3, 5'd2, 1'b0);
        in_valid = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // basic latency and sustained throughput
        out_ready = 1'b1;
        send(32'h7, 1'b0, 2'd0, 5'd3, 1'b0);
        chk("lat_out_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_out_result", out_result, 32'd7);
        chk("lat_out_rd", {27'd0, out_rd}, 32'd3);
        for (int i = 0; i < 6; i++) begin
            send(32'h100 + 32'(i), 1'b0, 2'd0, 5'(i + 4), 1'b0);
            chk("sustain_in_ready", {31'd0, in_ready}, 32'd1);
        end
        drain(10);

        // overflow rewrite for every opcode, and overflow with no opcode
        send(32'hDEAD_0001, 1'b1, 2'd1, 5'd5, 1'b1);
        send(32'hDEAD_0002, 1'b1, 2'd2, 5'd5, 1'b1);
        send(32'hDEAD_0003, 1'b1, 2'd3, 5'd5, 1'b1);
        send(32'hDEAD_0004, 1'b1, 2'd0, 5'd5, 1'b1);
        send(32'hDEAD_0005, 1'b0, 2'd2, 5'd6, 1'b0);
        drain(10);

        // backpressure: A, B fill the buffer, C held off
        out_ready = 1'b0;
        send(32'h11, 1'b0, 2'd0, 5'd1, 1'b0);
        send(32'h22, 1'b0, 2'd0, 5'd2, 1'b0);
        in_valid  = 1'b1;
        in_result = 32'h33;
        in_rd     = 5'd3;
        in_pc     = in_pc + 32'd4;
        #1;
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clock);
        tick();
        chk("bp_hold_result", out_result, 32'h11);
        out_ready = 1'b1;
        for (int i = 0; i < 4 && sb_q.size() < 3; i++) tick();
        in_valid = 1'b0;
        drain(10);

        // flush in TWO with an accept attempt, then in ONE with a real accept
        fill_two();
        flush    = 1'b1;
        in_valid = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush2_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        send(32'h44, 1'b0, 2'd0, 5'd4, 1'b0);
        flush = 1'b1;
        send(32'h55, 1'b0, 2'd0, 5'd5, 1'b0);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush1_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clock);
        drain(5);

        // asynchronous reset while holding two entries
        fill_two();
        #3;
        reset = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.delete();
        stab_pend = 1'b0;
        exp_cnt   = '0;
        @(negedge clock);
        reset = 1'b1;
        drain(5);

`ifdef EXC_COUNT_EN
        chk("cnt_after_reset", exc_count, 32'd0);
        send(32'h1, 1'b1, 2'd1, 5'd1, 1'b0);
        send(32'h2, 1'b1, 2'd2, 5'd1, 1'b0);
        send(32'h3, 1'b1, 2'd3, 5'd1, 1'b0);
        drain(10);
        out_ready = 1'b0;
        send(32'h4, 1'b1, 2'd1, 5'd1, 1'b0);
        flush    = 1'b1;
        in_valid = 1'b0;
        tick();
        flush = 1'b0;
        drain(5);
        chk("cnt_three", exc_count, 32'd3);
        force dut.exc_count_q = 32'hFFFF_FFFE;
        @(negedge clock);
        release dut.exc_count_q;
        exp_cnt   = 32'hFFFF_FFFE;
        out_ready = 1'b1;
        send(32'h5, 1'b1, 2'd3, 5'd1, 1'b0);
        send(32'h6, 1'b1, 2'd1, 5'd1, 1'b0);
        drain(10);
        chk("cnt_wrap", exc_count, 32'd0);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            out_ready     = ($urandom_range(0, 3) != 0);
            flush         = !out_ready && ($urandom_range(0, 19) == 0);
            in_valid      = ($urandom_range(0, 3) != 0);
            in_result     = $urandom;
            in_overflow   = ($urandom_range(0, 3) == 0);
            in_exc_op     = 2'($urandom_range(0, 3));
            in_rd         = 5'($urandom_range(0, 31));
            in_wen        = 1'($urandom_range(0, 1));
            in_mem_we     = 1'($urandom_range(0, 1));
            in_store_data = $urandom;
            in_pc         = $urandom;
            tick();
        end
        flush = 1'b0;
        drain(10);
`ifdef EXC_COUNT_EN
        chk("cnt_final", exc_count, exp_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
